uut_perf_capture: RTL and testbench
===================================

// Module: uut_perf_capture
// PURPOSE
//  Timing/capture stage between the autotest control unit and the UUT.
//  - Sequences the UUT reset and counts clk cycles until end_uut.
//  - Latches output_from_UUT.
//  - Streams a status/count/result frame as bytes to the SD write path.
//  - The control unit only handles block/byte writes to the sdspihost.
// PARAMETERS
//  OUTPUT_SIZE    32       width of output_from_UUT; multiple of 8
//  CNT_WIDTH      32       cycle counter width; multiple of 8
//  RST_CYCLES     16       cycles rst_uut is held high after start; >=1
//  TIMEOUT_CYCLES 1000000  RUN cycles before abort; < 2**CNT_WIDTH
// PORTS
//  clk             in   1            system clock
//  rst             in   1            asynchronous, active-low reset
//  start           in   1            1-cycle pulse: begin one measurement
//  busy            out  1            1 in any state other than IDLE
//  done            out  1            1-cycle pulse when last frame byte accepted
//  timeout         out  1            sticky: last run timed out; cleared on start
//  rst_uut         out  1            UUT reset, active-high
//  end_uut         in   1            UUT completion flag; level, may be async
//  output_from_UUT in   OUTPUT_SIZE  UUT result
//  byte_data       out  8            frame byte
//  byte_valid      out  1            byte_data valid
//  byte_ready      in   1            consumer accepts byte this cycle
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=IDLE; busy=0, done=0, timeout=0, rst_uut=1.
//   - byte_valid=0, byte_data=0; counters and capture regs = 0.
//  end_uut sync:
//   - 2-flop synchronizer to end_s; all logic uses end_s only.
//  FSM:
//   IDLE:
//    - start=1 -> RSTU; clear timeout and rst counter.
//    - start is ignored in every other state.
//   RSTU:
//    - rst_uut=1 for exactly RST_CYCLES cycles, then -> RUN.
//    - cycle counter = 0 on entry to RUN.
//   RUN:
//    - rst_uut=0; counter +1 per cycle.
//    - armed is set once end_s=0 has been seen in RUN.
//    - armed & end_s=1 -> CAPT.
//    - counter==TIMEOUT_CYCLES-1 and no end -> CAPT with timeout=1.
//    - end and timeout in the same cycle -> end wins (timeout=0).
//   CAPT (1 cycle):
//    - latch count and output_from_UUT.
//    - On timeout the result register is 0 and the count is TIMEOUT_CYCLES.
//    - rst_uut=1 from here on -> SEND.
//   SEND:
//    - emit frame of F = 1 + CNT_WIDTH/8 + OUTPUT_SIZE/8 bytes:
//      1. status: 8'h00 ok, 8'hFF timeout;
//      2. count, MSB byte first;
//      3. result, MSB byte first.
//    - Handshake: byte transferred when byte_valid & byte_ready.
//    - byte_data is held stable while byte_valid & !byte_ready.
//    - byte_valid is registered; next byte is presented the cycle after a transfer.
//    - Frame holds one byte per transfer, no gaps required.
//    - Last byte transfer -> DONE.
//   DONE (1 cycle):
//    - done=1, byte_valid=0 -> IDLE; rst_uut stays 1.
//  Count semantics:
//   - reported = real UUT cycles + 2 (synchronizer latency); software subtracts 2.
//  Mid-operation reset:
//   - Any state returns to IDLE immediately.
//   - Any partial frame is abandoned; no done pulse.
// TESTING
//  1. UUT model raises end_uut 100 cycles after rst_uut falls, ready=1,
//     result 32'hDEADBEEF.
//     -> frame 00 00 00 00 66 DE AD BE EF; done 1 cycle after last byte.
//  2. end_uut never rises, TIMEOUT_CYCLES=50.
//     -> timeout=1; frame FF 00 00 00 32 00 00 00 00.
//  3. end_uut stuck high through RSTU and RUN, falls after 10 cycles, rises at 30.
//     -> no early capture; count = 32 (30 + 2).
//  4. byte_ready toggles 1-0-0-1 randomly.
//     -> byte_data stable while stalled; 9 bytes exactly once, in order.
//  5. Pulse start during RUN and SEND.
//     -> ignored; one frame only; busy=1 throughout.
//  6. Assert rst mid-SEND after 3 bytes.
//     -> byte_valid=0, rst_uut=1, busy=0 immediately; the next start
//        produces a full fresh frame.

Source files
------------

// File: rtl/uut_perf_capture.sv
`default_nettype none
// ============================================================================
// Module   : uut_perf_capture
// Brief    : Resets the UUT, counts cycles until end_uut and streams the
//            status/count/result frame as bytes to the SD write path.
// Revision : 1.0
// ============================================================================
module uut_perf_capture #(
  parameter int OUTPUT_SIZE    = 32,
  parameter int CNT_WIDTH      = 32,
  parameter int RST_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic                   rst_uut,
  input  logic                   end_uut,
  input  logic [OUTPUT_SIZE-1:0] output_from_UUT,
  output logic [7:0]             byte_data,
  output logic                   byte_valid,
  input  logic                   byte_ready
);

  localparam int c_FRAME_BYTES = 1 + CNT_WIDTH/8 + OUTPUT_SIZE/8;
  localparam int c_FRAME_BITS  = 8 * c_FRAME_BYTES;
  localparam int c_BIDX_W      = $clog2(c_FRAME_BYTES);
  localparam int c_RCNT_W      = $clog2(RST_CYCLES + 1);

  localparam logic [CNT_WIDTH-1:0] c_TMO_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_TMO_CNT   = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [c_RCNT_W-1:0]  c_RST_LAST  = c_RCNT_W'(RST_CYCLES - 1);
  localparam logic [c_BIDX_W-1:0]  c_BIDX_LAST = c_BIDX_W'(c_FRAME_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RSTU = 3'd1,
    S_RUN  = 3'd2,
    S_CAPT = 3'd3,
    S_SEND = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t                  r_state;
  logic                    r_end_s1;
  logic                    r_end_s;
  logic                    r_armed;
  logic [c_RCNT_W-1:0]     r_rcnt;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic [c_FRAME_BITS-1:0] r_shift;
  logic [c_BIDX_W-1:0]     r_bidx;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_timeout;
  logic                    r_rst_uut;
  logic [7:0]              r_byte_data;
  logic                    r_byte_valid;

  logic [7:0]              w_status;
  logic [OUTPUT_SIZE-1:0]  w_result;
  logic [c_FRAME_BITS-1:0] w_frame;

  assign w_status = r_timeout ? 8'hFF : 8'h00;
  assign w_result = r_timeout ? '0 : output_from_UUT;
  assign w_frame  = {w_status, r_cnt, w_result};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_end_s1     <= 1'b0;
      r_end_s      <= 1'b0;
      r_armed      <= 1'b0;
      r_rcnt       <= '0;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_bidx       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_rst_uut    <= 1'b1;
      r_byte_data  <= 8'h00;
      r_byte_valid <= 1'b0;
    end else begin
      r_end_s1 <= end_uut;
      r_end_s  <= r_end_s1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_RSTU;
            r_timeout <= 1'b0;
            r_rcnt    <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_RSTU: begin
          if (r_rcnt == c_RST_LAST) begin
            r_state   <= S_RUN;
            r_rst_uut <= 1'b0;
            r_cnt     <= '0;
            r_armed   <= 1'b0;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
        end
        S_RUN: begin
          // A UUT still asserting end from a previous run must drop it first.
          if (!r_end_s) r_armed <= 1'b1;
          if (r_armed && r_end_s) begin
            r_state   <= S_CAPT;
            r_rst_uut <= 1'b1;
          end else if (r_cnt == c_TMO_LAST) begin
            r_state   <= S_CAPT;
            r_rst_uut <= 1'b1;
            r_timeout <= 1'b1;
            r_cnt     <= c_TMO_CNT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CAPT: begin
          r_byte_data  <= w_frame[c_FRAME_BITS-1 -: 8];
          r_shift      <= w_frame << 8;
          r_byte_valid <= 1'b1;
          r_bidx       <= '0;
          r_state      <= S_SEND;
        end
        S_SEND: begin
          if (r_byte_valid && byte_ready) begin
            if (r_bidx == c_BIDX_LAST) begin
              r_byte_valid <= 1'b0;
              r_done       <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_byte_data <= r_shift[c_FRAME_BITS-1 -: 8];
              r_shift     <= r_shift << 8;
              r_bidx      <= r_bidx + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign rst_uut    = r_rst_uut;
  assign byte_data  = r_byte_data;
  assign byte_valid = r_byte_valid;

endmodule
`default_nettype wire

// File: tb/tb_uut_perf_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_uut_perf_capture
// Brief    : Self-checking bench: directed vector table plus randomized runs
//            against a cycle-level model of the UUT end flag.
// Revision : 1.0
// ============================================================================
module tb_uut_perf_capture;

  localparam int OUTPUT_SIZE    = 32;
  localparam int CNT_WIDTH      = 32;
  localparam int RST_CYCLES     = 16;
  localparam int TIMEOUT_CYCLES = 120;
  localparam int FRAME_BYTES    = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        rst_uut;
  logic        end_uut;
  logic [31:0] output_from_UUT;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;

  int checks   = 0;
  int failures = 0;

  // UUT behaviour: end is m_hi while in reset, m_hi for the first m_d1
  // cycles after reset release, and 1 from cycle m_d2 onward.
  int uut_cnt = -1;
  bit m_hi    = 1'b0;
  int m_d1    = 0;
  int m_d2    = 1000000;
  int rp      = 0;

  uut_perf_capture #(
    .OUTPUT_SIZE   (OUTPUT_SIZE),
    .CNT_WIDTH     (CNT_WIDTH),
    .RST_CYCLES    (RST_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .timeout        (timeout),
    .rst_uut        (rst_uut),
    .end_uut        (end_uut),
    .output_from_UUT(output_from_UUT),
    .byte_data      (byte_data),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic uut_level(input int j);
    if (j < 0) return m_hi;
    return (m_hi && j < m_d1) || (j >= m_d2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_uut === 1'b1) uut_cnt = -1;
    else uut_cnt++;
    end_uut = uut_level(uut_cnt);
  endtask

  function automatic logic rdy(input int mode);
    rp++;
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom % 2);
      default: return (rp % 4 == 0) || (rp % 4 == 3);
    endcase
  endfunction

  // The DUT sees end two cycles late; capture needs a low seen first in RUN.
  task automatic ref_model(input logic [31:0] res, output logic [7:0] st,
                           output logic [31:0] cnt, output logic [31:0] r);
    bit   seen_low;
    int   cap;
    logic lv;
    seen_low = 1'b0;
    cap      = -1;
    for (int k = 0; k < TIMEOUT_CYCLES; k++) begin
      lv = uut_level(k - 2);
      if (seen_low && lv) begin
        cap = k;
        break;
      end
      if (!lv) seen_low = 1'b1;
    end
    if (cap >= 0) begin
      st = 8'h00; cnt = 32'(cap); r = res;
    end else begin
      st = 8'hFF; cnt = 32'(TIMEOUT_CYCLES); r = 32'h0;
    end
  endtask

  task automatic run_one(input string nm, input logic [31:0] res, input int rdy_mode,
                         input bit poke, input int abort_after, input logic [7:0] e_st,
                         input logic [31:0] e_cnt, input logic [31:0] e_res);
    logic [71:0] fr;
    logic [7:0]  prev_data;
    int          got;
    int          rst_hi;
    bit          fin, done_ok, done_bad, busy_bad, stall_bad, prev_stall;
    bit          poked_run, poked_send, rst_fell, quiet_bad, rstu_at_done;
    fr = {e_st, e_cnt, e_res};
    got = 0; rst_hi = 0; prev_data = 8'h00;
    fin = 0; done_ok = 0; done_bad = 0; busy_bad = 0; stall_bad = 0; prev_stall = 0;
    poked_run = 0; poked_send = 0; rst_fell = 0; quiet_bad = 0; rstu_at_done = 0;
    output_from_UUT = res;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({nm, "/timeout_clr"}, 32'(timeout), 32'h0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (fin) begin
        done_ok      = (done === 1'b1);
        rstu_at_done = (rst_uut === 1'b1);
        break;
      end
      if (done !== 1'b0) done_bad = 1'b1;
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (!rst_fell) begin
        if (rst_uut === 1'b1) rst_hi++;
        else rst_fell = 1'b1;
      end
      if (prev_stall && (byte_valid !== 1'b1 || byte_data !== prev_data)) stall_bad = 1'b1;
      if (poke && !poked_run && uut_cnt == 20) begin
        start = 1'b1; poked_run = 1'b1;
      end else if (poke && !poked_send && got == 1) begin
        start = 1'b1; poked_send = 1'b1;
      end else begin
        start = 1'b0;
      end
      byte_ready = rdy(rdy_mode);
      prev_stall = 1'b0;
      if (byte_valid === 1'b1 && byte_ready) begin
        if (got < FRAME_BYTES)
          check($sformatf("%s/byte%0d", nm, got), 32'(byte_data), 32'(fr[71 - 8*got -: 8]));
        else
          check($sformatf("%s/extra_byte", nm), 32'(got), 32'(FRAME_BYTES - 1));
        got++;
        fin = (got == FRAME_BYTES);
      end else if (byte_valid === 1'b1) begin
        prev_stall = 1'b1;
        prev_data  = byte_data;
      end
      if (abort_after > 0 && got == abort_after) break;
      tick();
    end
    start = 1'b0;
    if (abort_after > 0) begin
      check({nm, "/bytes_before_abort"}, 32'(got), 32'(abort_after));
      tick();
      #2 rst = 1'b0;
      #1;
      check({nm, "/abort_valid"}, 32'(byte_valid), 32'h0);
      check({nm, "/abort_rst_uut"}, 32'(rst_uut), 32'h1);
      check({nm, "/abort_busy"}, 32'(busy), 32'h0);
      byte_ready = 1'b0;
      repeat (3) begin
        tick();
        if (done !== 1'b0) done_bad = 1'b1;
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (3) begin
        tick();
        if (done !== 1'b0 || busy !== 1'b0) done_bad = 1'b1;
      end
      check({nm, "/abort_no_done"}, 32'(done_bad), 32'h0);
      return;
    end
    check({nm, "/frame_len"}, 32'(got), 32'(FRAME_BYTES));
    check({nm, "/done_pulse"}, 32'(done_ok), 32'h1);
    check({nm, "/rst_uut_at_done"}, 32'(rstu_at_done), 32'h1);
    check({nm, "/early_done"}, 32'(done_bad), 32'h0);
    check({nm, "/busy_during"}, 32'(busy_bad), 32'h0);
    check({nm, "/stall_hold"}, 32'(stall_bad), 32'h0);
    check({nm, "/rst_uut_cycles"}, 32'(rst_hi), 32'(RST_CYCLES));
    byte_ready = 1'b0;
    tick();
    check({nm, "/idle_busy"}, 32'(busy), 32'h0);
    check({nm, "/done_width"}, 32'(done), 32'h0);
    check({nm, "/timeout_flag"}, 32'(timeout), 32'(e_st == 8'hFF));
    repeat (20) begin
      tick();
      if (busy !== 1'b0 || byte_valid !== 1'b0) quiet_bad = 1'b1;
    end
    check({nm, "/single_frame"}, 32'(quiet_bad), 32'h0);
  endtask

  typedef struct {
    string       nm;
    bit          hi;
    int          d1;
    int          d2;
    logic [31:0] res;
    int          rdy;
    bit          poke;
    int          abort_n;
    logic [7:0]  st;
    logic [31:0] cnt;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [7:0]  st;
    logic [31:0] cnt;
    logic [31:0] r;
    logic [31:0] res;
    vecs[0] = '{"basic",      1'b0, 0,    100,     32'hDEADBEEF, 0, 1'b0, 0, 8'h00, 32'd102, 32'hDEADBEEF};
    vecs[1] = '{"timeout",    1'b0, 0,    1000000, 32'h12345678, 0, 1'b0, 0, 8'hFF, 32'd120, 32'h0};
    vecs[2] = '{"stuck_high", 1'b1, 10,   30,      32'hA5A50F0F, 0, 1'b0, 0, 8'h00, 32'd32,  32'hA5A50F0F};
    vecs[3] = '{"stall",      1'b0, 0,    55,      32'h01234567, 2, 1'b0, 0, 8'h00, 32'd57,  32'h01234567};
    vecs[4] = '{"start_poke", 1'b0, 0,    40,      32'hCAFEF00D, 1, 1'b1, 0, 8'h00, 32'd42,  32'hCAFEF00D};
    vecs[5] = '{"end_wins",   1'b0, 0,    117,     32'h11223344, 0, 1'b0, 0, 8'h00, 32'd119, 32'h11223344};
    vecs[6] = '{"just_late",  1'b0, 0,    118,     32'h55667788, 0, 1'b0, 0, 8'hFF, 32'd120, 32'h0};
    vecs[7] = '{"abort",      1'b0, 0,    20,      32'h99AABBCC, 1, 1'b0, 3, 8'h00, 32'd22,  32'h99AABBCC};
    vecs[8] = '{"after_abort",1'b0, 0,    0,       32'h0BADC0DE, 1, 1'b0, 0, 8'h00, 32'd2,   32'h0BADC0DE};
    vecs[9] = '{"never_low",  1'b1, 1000, 5,       32'h77777777, 0, 1'b0, 0, 8'hFF, 32'd120, 32'h0};

    rst = 1'b0; start = 1'b0; end_uut = 1'b0; byte_ready = 1'b0;
    output_from_UUT = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/busy",       32'(busy),       32'h0);
    check("reset/done",       32'(done),       32'h0);
    check("reset/timeout",    32'(timeout),    32'h0);
    check("reset/rst_uut",    32'(rst_uut),    32'h1);
    check("reset/byte_valid", 32'(byte_valid), 32'h0);
    check("reset/byte_data",  32'(byte_data),  32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) tick();
    check("idle/busy", 32'(busy), 32'h0);

    for (int i = 0; i < 10; i++) begin
      m_hi = vecs[i].hi; m_d1 = vecs[i].d1; m_d2 = vecs[i].d2;
      run_one(vecs[i].nm, vecs[i].res, vecs[i].rdy, vecs[i].poke, vecs[i].abort_n,
              vecs[i].st, vecs[i].cnt, vecs[i].r);
    end

    for (int i = 0; i < 8; i++) begin
      m_hi = ($urandom % 3 == 0);
      m_d1 = $urandom_range(0, 40);
      m_d2 = $urandom_range(0, 125);
      res  = $urandom;
      ref_model(res, st, cnt, r);
      run_one($sformatf("rand%0d", i), res, int'($urandom % 3), 1'b0, 0, st, cnt, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
